// File: rtl/bpu_update_sched.sv
// bpu_update_sched: merges the front-end and back-end BPU update producers
// onto the single BPU update port.
//  - Flush updates pass through combinationally. A back flush wins over a
//    front flush.
//  - Training-only updates (btb_update | lpht_update) are queued in a small
//    FIFO and issued one per cycle, in the cycles that carry no flush.
//  - A back flush discards the same-cycle front input. It also turns every
//    queued front-sourced entry into a bubble: the slot stays in the FIFO,
//    but it issues as an all-zero update.
//  - Training that does not fit in the FIFO is dropped and counted.
// Optional feature, macro BPU_UPD_BYPASS_EN: when the FIFO is empty and no
// flush is output, one training input goes straight to update_o in the same
// cycle. If both inputs train, back bypasses and front is queued.

package bpu_update_sched_pkg;

  typedef struct packed {
    logic        flush;
    logic [31:0] pc;
    logic [31:0] br_target;
    logic [1:0]  br_type;
    logic        br_taken;
    logic        btb_update;
    logic        lpht_update;
    logic [1:0]  lphr;
    logic [9:0]  lphr_index;
  } bpu_update_t;

  // One FIFO slot. valid=0 marks a front entry cancelled by a back flush.
  // src: 0 = front end, 1 = back end.
  typedef struct packed {
    logic        valid;
    logic        src;
    bpu_update_t upd;
  } q_entry_t;

endpackage

module bpu_update_sched
  import bpu_update_sched_pkg::*;
#(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  bpu_update_t             update_front_i,
  input  bpu_update_t             update_back_i,
  output bpu_update_t             update_o,
  output logic [$clog2(DEPTH):0]  q_count_o,
  output logic [CNT_W-1:0]        drop_cnt_o,
  output logic                    busy_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_QW = PTR_W + 1;
  localparam int FREE_W = CNT_QW + 1;
  localparam logic [FREE_W-1:0] DEPTH_F = FREE_W'(DEPTH);
  localparam logic [CNT_W-1:0]  DROP_MAX = '1;

  // Queued training never carries the flush flag.
  function automatic bpu_update_t as_training(input bpu_update_t u);
    bpu_update_t r;
    r       = u;
    r.flush = 1'b0;
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  q_entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_QW-1:0]    count_q, count_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic back_flush, front_flush, flush_out;
  logic back_train, front_train;
  logic q_empty, pop;
  logic bypass_back, bypass_front;
  logic push_back_req, push_front_req;
  logic accept_back, accept_front;
  logic drop_back, drop_front;
  logic [FREE_W-1:0]  free_slots;
  logic [CNT_QW-1:0]  n_push;
  logic [PTR_W-1:0]   front_slot;
  logic [1:0]         n_drop;
  logic [CNT_W:0]     drop_sum;
  q_entry_t           head;

  assign back_flush  = update_back_i.flush;
  assign front_flush = update_front_i.flush;
  assign flush_out   = back_flush | front_flush;

  // A flushing input's training goes out with the flush and is never queued.
  // A back flush also discards the front input of the same cycle.
  assign back_train  = (update_back_i.btb_update | update_back_i.lpht_update)
                       & ~back_flush;
  assign front_train = (update_front_i.btb_update | update_front_i.lpht_update)
                       & ~front_flush & ~back_flush;

  assign q_empty = (count_q == '0);
  assign pop     = ~flush_out & ~q_empty;
  assign head    = mem_q[rd_ptr_q];

`ifdef BPU_UPD_BYPASS_EN
  assign bypass_back  = ~flush_out & q_empty & back_train;
  assign bypass_front = ~flush_out & q_empty & ~back_train & front_train;
`else
  assign bypass_back  = 1'b0;
  assign bypass_front = 1'b0;
`endif

  assign push_back_req  = back_train  & ~bypass_back;
  assign push_front_req = front_train & ~bypass_front;

  // The slot freed by this cycle's pop can be reused in the same cycle.
  // Back has priority for the available space.
  assign free_slots   = DEPTH_F - FREE_W'(count_q) + FREE_W'(pop);
  assign accept_back  = push_back_req  & (free_slots != '0);
  assign accept_front = push_front_req & (free_slots > FREE_W'(accept_back));
  assign drop_back    = push_back_req  & ~accept_back;
  assign drop_front   = push_front_req & ~accept_front;

  assign n_push     = CNT_QW'(accept_back) + CNT_QW'(accept_front);
  assign front_slot = wr_ptr_q + PTR_W'(accept_back);
  assign n_drop     = 2'(drop_back) + 2'(drop_front);

  // Next-state arithmetic for pointers, occupancy and the saturating drop counter.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + n_push - CNT_QW'(pop);
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(n_drop);
    drop_cnt_d = drop_sum[CNT_W] ? DROP_MAX : drop_sum[CNT_W-1:0];
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------

  // Pointers, occupancy and the drop counter. Reset empties the queue
  // asynchronously, so anything in flight is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values, independent of block order.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Queue storage: back-flush cancellation, then this cycle's writes.
  // Back is written ahead of front.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; occupancy is tracked by count_q, and slots are only read after they are written.
    if (back_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!mem_q[i].src) mem_q[i].valid <= 1'b0;
      end
    end
    if (accept_back) begin
      mem_q[wr_ptr_q] <= '{valid: 1'b1, src: 1'b1,
                           upd: as_training(update_back_i)};
    end
    if (accept_front) begin
      mem_q[front_slot] <= '{valid: 1'b1, src: 1'b0,
                             upd: as_training(update_front_i)};
    end
  end

  // ---------------------------------------------------------------------
  // Output select: flush > bypass > queue head
  // ---------------------------------------------------------------------

  // Merged update. It is forced to zero while reset is held.
  always_comb begin
    update_o = '0;
    if (rst_n) begin
      if (back_flush) begin
        update_o = update_back_i;
      end else if (front_flush) begin
        update_o = update_front_i;
      end else if (bypass_back) begin
        update_o = update_back_i;
      end else if (bypass_front) begin
        update_o = update_front_i;
      end else if (pop && head.valid) begin
        update_o = as_training(head.upd);
      end
    end
  end

  assign q_count_o  = count_q;
  assign busy_o     = ~q_empty;
  assign drop_cnt_o = drop_cnt_q;

endmodule
